// File: rtl/cook_timer.sv
// cook_timer: oven cook-time countdown in mm:ss, held as four BCD digits.
//
// The user loads a time with the add_min / add_sec pulses, then starts,
// pauses or cancels the countdown. While running, a prescaler divides clk
// down to one-second ticks. Each tick removes one second. Reaching 00:00
// enters DONE, where the beeper sounds for BEEP_SECONDS and then the block
// returns to IDLE by itself.
//
// Parameters:
//   TICKS_PER_SEC  clk cycles per second (prescaler wraps at TICKS_PER_SEC-1)
//   BEEP_SECONDS   seconds spent beeping in DONE before returning to IDLE
//
// Ports:
//   clk        in   system clock, sole clock
//   rst        in   synchronous, active-high reset
//   add_min    in   1-cycle pulse: +1 minute (saturates at 59)
//   add_sec    in   1-cycle pulse: +1 second with carry (saturates at 59:59)
//   start      in   1-cycle pulse: start / resume the countdown
//   stop       in   1-cycle pulse: pause / cancel / acknowledge
//   door_open  in   level: oven door is open
//   sec_ones   out  BCD 0-9
//   sec_tens   out  BCD 0-5
//   min_ones   out  BCD 0-9
//   min_tens   out  BCD 0-5
//   heating    out  high only in RUN
//   beep       out  high only in DONE
//   state      out  IDLE=0 RUN=1 PAUSE=2 DONE=3
//
// Every output comes straight from a flop.
// When several inputs arrive in the same cycle, they take effect in this
// order: rst > stop > door_open > start > add.
module cook_timer #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int BEEP_SECONDS  = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       add_min,
  input  logic       add_sec,
  input  logic       start,
  input  logic       stop,
  input  logic       door_open,
  output logic [3:0] sec_ones,
  output logic [2:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [2:0] min_tens,
  output logic       heating,
  output logic       beep,
  output logic [1:0] state
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int BW = (BEEP_SECONDS > 1) ? $clog2(BEEP_SECONDS) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICKS_PER_SEC - 1);
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_SECONDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Time is packed as {min_tens[13:11], min_ones[10:7], sec_tens[6:4], sec_ones[3:0]}.
  localparam logic [13:0] TIME_MAX = {3'd5, 4'd9, 3'd5, 4'd9};

  state_t      state_q, state_d;
  logic [13:0] time_q, time_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] beep_cnt_q, beep_cnt_d;
  logic        heating_q, beep_q;

  logic        time_zero;
  logic        tick;
  logic [13:0] time_inc_min, time_inc_sec, time_dec;

  // +1 minute; the seconds digits are left alone. Minutes stay at 59 once there.
  function automatic logic [13:0] f_inc_min(input logic [13:0] t);
    logic [2:0] mt;
    logic [3:0] mo;
    mt = t[13:11];
    mo = t[10:7];
    if (!(mt == 3'd5 && mo == 4'd9)) begin
      if (mo == 4'd9) begin
        mo = 4'd0;
        mt = mt + 3'd1;
      end else begin
        mo = mo + 4'd1;
      end
    end
    return {mt, mo, t[6:0]};
  endfunction

  // +1 second, carrying from xx:59 into the minutes; the time stays at 59:59 once there.
  function automatic logic [13:0] f_inc_sec(input logic [13:0] t);
    logic [2:0] st;
    logic [3:0] so;
    logic [13:0] r;
    st = t[6:4];
    so = t[3:0];
    r  = t;
    if (t == TIME_MAX) begin
      r = t;
    end else if (st == 3'd5 && so == 4'd9) begin
      // Minutes cannot be 59 here, otherwise t would be 59:59.
      r = f_inc_min({t[13:7], 7'd0});
    end else if (so == 4'd9) begin
      r = {t[13:7], st + 3'd1, 4'd0};
    end else begin
      r = {t[13:7], st, so + 4'd1};
    end
    return r;
  endfunction

  // -1 second with BCD borrow. Only used while time is nonzero.
  function automatic logic [13:0] f_dec_sec(input logic [13:0] t);
    logic [2:0] mt;
    logic [3:0] mo;
    logic [2:0] st;
    logic [3:0] so;
    mt = t[13:11];
    mo = t[10:7];
    st = t[6:4];
    so = t[3:0];
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else if (st != 3'd0) begin
      st = st - 3'd1;
      so = 4'd9;
    end else begin
      st = 3'd5;
      so = 4'd9;
      if (mo != 4'd0) begin
        mo = mo - 4'd1;
      end else begin
        mo = 4'd9;
        mt = mt - 3'd1;
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign time_zero    = (time_q == 14'd0);
  assign tick         = (presc_q == PRE_LAST);
  assign time_inc_min = f_inc_min(time_q);
  assign time_inc_sec = f_inc_sec(time_q);
  assign time_dec     = f_dec_sec(time_q);

  // Next-state and datapath logic.
  always_comb begin
    state_d    = state_q;
    time_d     = time_q;
    presc_d    = presc_q;
    beep_cnt_d = beep_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (stop) begin
          time_d = 14'd0;
        end else if (start) begin
          // A start pulse takes the cycle even when it is refused, so an add
          // pulse arriving in the same cycle is dropped.
          if (!time_zero && !door_open) begin
            state_d = ST_RUN;
            presc_d = '0;
          end
        end else if (add_min) begin
          time_d = time_inc_min;
        end else if (add_sec) begin
          time_d = time_inc_sec;
        end
      end

      ST_RUN: begin
        if (stop || door_open) begin
          // Pausing takes priority over a tick that falls in the same cycle.
          state_d = ST_PAUSE;
        end else if (tick) begin
          presc_d = '0;
          time_d  = time_dec;
          if (time_dec == 14'd0) begin
            state_d    = ST_DONE;
            beep_cnt_d = '0;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end

      ST_PAUSE: begin
        if (stop) begin
          state_d = ST_IDLE;
          time_d  = 14'd0;
        end else if (start) begin
          if (!door_open && !time_zero) begin
            state_d = ST_RUN;
            presc_d = '0;
          end
        end else if (add_min) begin
          time_d = time_inc_min;
        end else if (add_sec) begin
          time_d = time_inc_sec;
        end
      end

      ST_DONE: begin
        // The prescaler keeps counting seconds; beep_cnt counts the seconds
        // of beeping.
        if (stop) begin
          state_d = ST_IDLE;
          time_d  = 14'd0;
        end else if (tick) begin
          presc_d = '0;
          if (beep_cnt_q == BEEP_LAST) begin
            state_d = ST_IDLE;
            time_d  = 14'd0;
          end else begin
            beep_cnt_d = beep_cnt_q + 1'b1;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        time_d  = 14'd0;
      end
    endcase
  end

  // State register. heating and beep are decoded from the next state so that
  // they change on the same edge as state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      time_q     <= 14'd0;
      presc_q    <= '0;
      beep_cnt_q <= '0;
      heating_q  <= 1'b0;
      beep_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      time_q     <= time_d;
      presc_q    <= presc_d;
      beep_cnt_q <= beep_cnt_d;
      heating_q  <= (state_d == ST_RUN);
      beep_q     <= (state_d == ST_DONE);
    end
  end

  assign min_tens = time_q[13:11];
  assign min_ones = time_q[10:7];
  assign sec_tens = time_q[6:4];
  assign sec_ones = time_q[3:0];
  assign heating  = heating_q;
  assign beep     = beep_q;
  assign state    = state_q;

endmodule

// File: tb/tb_cook_timer.sv
// tb_cook_timer: directed bench for cook_timer (TICKS_PER_SEC=4, BEEP_SECONDS=2).
// Expected snapshots {state, mm, ss, heating, beep} are pushed to a queue when
// the stimulus is driven. They are popped and compared with the DUT outputs
// 1 time unit after the active edge.
module tb_cook_timer;

  localparam int TPS  = 4;
  localparam int BEEP = 2;
  localparam int IDLE = 0, RUN = 1, PAUSE = 2, DONE = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       add_min = 1'b0, add_sec = 1'b0, start = 1'b0, stop = 1'b0, door_open = 1'b0;
  logic [3:0] sec_ones, min_ones;
  logic [2:0] sec_tens, min_tens;
  logic       heating, beep;
  logic [1:0] state;

  logic [17:0] exp_q[$];
  string       tag_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  cook_timer #(.TICKS_PER_SEC(TPS), .BEEP_SECONDS(BEEP)) dut (
    .clk(clk), .rst(rst), .add_min(add_min), .add_sec(add_sec), .start(start),
    .stop(stop), .door_open(door_open), .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens), .heating(heating), .beep(beep),
    .state(state)
  );

  // Clock and global time limit.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  // Pack an expectation from plain integer minutes and seconds.
  function automatic logic [17:0] pk(int st, int m, int s, int h, int b);
    return {2'(st), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10), 1'(h), 1'(b)};
  endfunction

  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ex(string tag, int st, int m, int s, int h, int b);
    exp_q.push_back(pk(st, m, s, h, b));
    tag_q.push_back(tag);
  endtask

  task automatic compare();
    logic [17:0] e, o;
    string t;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard: no expectation queued");
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = {state, min_tens, min_ones, sec_tens, sec_ones, heating, beep};
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed st=%0d %0d%0d:%0d%0d h=%b b=%b, expected st=%0d %0d%0d:%0d%0d h=%b b=%b",
             t, o[17:16], o[15:13], o[12:9], o[8:6], o[5:2], o[1], o[0],
             e[17:16], e[15:13], e[12:9], e[8:6], e[5:2], e[1], e[0]);
    end
  endtask

  // Pulse drivers: raise for one edge, then drop.
  task automatic p_min(); add_min = 1'b1; cyc(1); add_min = 1'b0; endtask
  task automatic p_sec(); add_sec = 1'b1; cyc(1); add_sec = 1'b0; endtask
  task automatic p_start(); start = 1'b1; cyc(1); start = 1'b0; endtask
  task automatic p_stop(); stop = 1'b1; cyc(1); stop = 1'b0; endtask

  initial begin
    // 1. reset, start at 00:00 ignored
    cyc(1);
    ex("reset", IDLE, 0, 0, 0, 0);
    rst = 1'b0;
    compare();
    ex("start_at_zero", IDLE, 0, 0, 0, 0);
    p_start(); compare();

    // 2. load 01:03 and count down to DONE
    ex("add_min_1", IDLE, 1, 0, 0, 0);
    p_min(); compare();
    for (int i = 1; i <= 3; i++) begin
      ex("add_sec_load", IDLE, 1, i, 0, 0);
      p_sec(); compare();
    end
    ex("start_run", RUN, 1, 3, 1, 0);
    p_start(); compare();
    ex("no_early_tick", RUN, 1, 3, 1, 0);
    cyc(3); compare();
    ex("first_tick", RUN, 1, 2, 1, 0);
    cyc(1); compare();
    ex("three_sec", RUN, 1, 0, 1, 0);
    cyc(8); compare();
    ex("min_borrow", RUN, 0, 59, 1, 0);
    cyc(4); compare();
    ex("last_second", RUN, 0, 1, 1, 0);
    cyc(235); compare();
    ex("done_entry", DONE, 0, 0, 0, 1);
    cyc(1); compare();
    // 6. beep lasts exactly 8 cycles
    ex("beep_hold", DONE, 0, 0, 0, 1);
    cyc(7); compare();
    ex("beep_end", IDLE, 0, 0, 0, 0);
    cyc(1); compare();

    // 3. carry and saturation
    for (int i = 0; i < 59; i++) p_sec();
    ex("sec_59", IDLE, 0, 59, 0, 0);
    cyc(0); compare();
    ex("sec_carry", IDLE, 1, 0, 0, 0);
    p_sec(); compare();
    for (int i = 0; i < 58; i++) p_min();
    for (int i = 0; i < 59; i++) p_sec();
    ex("load_max", IDLE, 59, 59, 0, 0);
    cyc(0); compare();
    ex("sec_saturate", IDLE, 59, 59, 0, 0);
    p_sec(); compare();
    ex("min_saturate", IDLE, 59, 59, 0, 0);
    p_min(); compare();
    ex("idle_stop_clear", IDLE, 0, 0, 0, 0);
    p_stop(); compare();
    ex("min_and_sec", IDLE, 1, 0, 0, 0);
    add_min = 1'b1; add_sec = 1'b1; cyc(1); add_min = 1'b0; add_sec = 1'b0;
    compare();
    p_stop();

    // 4. door opens on a tick edge -> PAUSE without a decrement
    for (int i = 0; i < 10; i++) p_sec();
    ex("run_10", RUN, 0, 10, 1, 0);
    p_start(); compare();
    cyc(3);
    ex("door_pause", PAUSE, 0, 10, 0, 0);
    door_open = 1'b1; cyc(1); compare();
    ex("pause_frozen", PAUSE, 0, 10, 0, 0);
    cyc(10); compare();
    ex("start_door_open", PAUSE, 0, 10, 0, 0);
    p_start(); compare();
    door_open = 1'b0;
    ex("door_closed", PAUSE, 0, 10, 0, 0);
    cyc(1); compare();
    ex("resume", RUN, 0, 10, 1, 0);
    p_start(); compare();
    ex("resume_no_tick", RUN, 0, 10, 1, 0);
    cyc(3); compare();
    ex("resume_tick", RUN, 0, 9, 1, 0);
    cyc(1); compare();

    // 5. stop pauses, second stop cancels
    ex("stop_pause", PAUSE, 0, 9, 0, 0);
    p_stop(); compare();
    ex("stop_cancel", IDLE, 0, 0, 0, 0);
    p_stop(); compare();
    for (int i = 0; i < 5; i++) p_sec();
    ex("idle_05", IDLE, 0, 5, 0, 0);
    cyc(0); compare();
    ex("idle_05_stop", IDLE, 0, 0, 0, 0);
    p_stop(); compare();
    for (int i = 0; i < 5; i++) p_sec();
    p_start();
    cyc(2);
    ex("rst_mid_run", IDLE, 0, 0, 0, 0);
    rst = 1'b1; cyc(1); rst = 1'b0; compare();
    // The prescaler must restart from 0: 00:01 runs exactly 4 edges.
    p_sec();
    p_start();
    ex("presc_cleared", RUN, 0, 1, 1, 0);
    cyc(3); compare();
    ex("done_again", DONE, 0, 0, 0, 1);
    cyc(1); compare();

    // 6. adds and start are ignored in DONE; stop on the 3rd DONE edge
    ex("done_add_ignored", DONE, 0, 0, 0, 1);
    p_min(); compare();
    ex("done_start_ignored", DONE, 0, 0, 0, 1);
    p_start(); compare();
    ex("done_stop", IDLE, 0, 0, 0, 0);
    p_stop(); compare();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
